// File: rtl/dm_block_copy.sv
// dm_block_copy: copies LEN words from SRC to DST, one read then one write per word.
module dm_block_copy #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, waddr_q, waddr_d;
  logic [ADDR_W:0] len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic last;
  assign last = idx_q == len_q - (ADDR_W+1)'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      waddr_q <= waddr_d;
    end
  end
  // Write address and data are captured on the READ edge so they hold outside WRITE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    waddr_d = waddr_q;
    case (state_q)
      IDLE: if (start_i) begin
        src_d   = src_i;
        dst_d   = dst_i;
        len_d   = len_i;
        idx_d   = '0;
        state_d = len_i == '0 ? DONE : READ;
      end
      READ: begin
        buf_d   = mem_rdata_i;
        waddr_d = dst_q + idx_q[ADDR_W-1:0];
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = last ? idx_q : idx_q + (ADDR_W+1)'(1);
        state_d = last ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_o      = state_q == READ || state_q == WRITE;
  assign done_o      = state_q == DONE;
  assign mem_we_o    = state_q == WRITE;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = buf_q;
  assign mem_raddr_o = src_q + idx_q[ADDR_W-1:0];
endmodule

// File: tb/tb_dm_block_copy.sv
// tb_dm_block_copy: randomized block copies against a memory-level reference model with a scoreboard.
module tb_dm_block_copy;
  localparam int AW = 7, DW = 32, N = 128;
  logic clk = 0, rst_n = 0, start_i = 0;
  logic [AW-1:0] src_i = '0, dst_i = '0;
  logic [AW:0] len_i = '0;
  logic busy_o, done_o, mem_we_o;
  logic [AW-1:0] mem_waddr_o, mem_raddr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  always #5 clk = ~clk;
  dm_block_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i)
  );
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ref_m [N];
  logic tb_we = 0;
  logic [AW-1:0] tb_a = '0;
  logic [DW-1:0] tb_d = '0;
  assign mem_rdata_i = mem[mem_raddr_o];
  always @(posedge clk) if (mem_we_o) mem[mem_waddr_o] <= mem_wdata_o; else if (tb_we) mem[tb_a] <= tb_d;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wq[$];
  logic [AW-1:0] rq[$];
  int dq_cyc[$], dq_busy[$];
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (busy_o) busy_cnt++;
    if (mem_we_o) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("waddr", mem_waddr_o, w.a);
        chk("wdata", mem_wdata_o, w.d);
      end
      chk("rw_same_addr", mem_raddr_o == mem_waddr_o, 0);
    end else if (busy_o) begin
      if (rq.size() == 0) chk("unexpected_read", 1, 0);
      else chk("raddr", mem_raddr_o, rq.pop_front());
    end
    if (done_o) begin
      chk("done_busy_overlap", busy_o, 0);
      if (dq_cyc.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_cycle", cyc, dq_cyc.pop_front());
        chk("busy_cycles", busy_cnt, dq_busy.pop_front());
      end
      busy_cnt = 0;
    end
  end
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1; tb_a = a; tb_d = v; ref_m[a] = v;
    @(posedge clk);
    #1 tb_we = 0;
  endtask
  // Reference: forward copy word by word, so overlapping ranges replicate the source.
  task automatic copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
    @(negedge clk);
    start_i = 1; src_i = s; dst_i = d; len_i = l;
    for (int i = 0; i < int'(l); i++) begin
      rq.push_back(AW'(int'(s) + i));
      ref_m[AW'(int'(d) + i)] = ref_m[AW'(int'(s) + i)];
      wq.push_back('{AW'(int'(d) + i), ref_m[AW'(int'(d) + i)]});
    end
    @(posedge clk);
    #1 start_i = 0;
    src_i = AW'($urandom); dst_i = AW'($urandom); len_i = (AW+1)'($urandom);
    dq_cyc.push_back(cyc + 2 * int'(l));
    dq_busy.push_back(2 * int'(l));
  endtask
  task automatic wait_done(input int l);
    for (int i = 0; i < 2 * l + 20 && dq_cyc.size() != 0; i++) @(negedge clk);
    chk("done_timeout", dq_cyc.size(), 0);
    chk("writes_left", wq.size(), 0);
    chk("reads_left", rq.size(), 0);
    @(negedge clk);
  endtask
  task automatic chk_mem(input string nm);
    int errs = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_m[i]) errs++;
    chk(nm, errs, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_waddr", mem_waddr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_raddr", mem_raddr_o, 0);
    rst_n = 1;
    for (int i = 0; i < N; i++) poke(AW'(i), $urandom);
    for (int i = 0; i < 4; i++) poke(AW'(8'h10 + i), DW'(32'hA0 + i));
    copy(7'h10, 7'h40, 4); wait_done(4); chk_mem("mem_copy4");
    for (int i = 0; i < 4; i++) chk("copy4_word", mem[8'h40 + i], DW'(32'hA0 + i));
    copy(7'h05, 7'h06, 0); wait_done(0); chk_mem("mem_len0");
    copy(7'h7E, 7'h01, 4); wait_done(4); chk_mem("mem_wrap");
    copy(7'h30, 7'h50, 3);
    repeat (2) @(negedge clk);
    start_i = 1; src_i = 7'h20; dst_i = 7'h24; len_i = 5;
    @(posedge clk);
    #1 start_i = 0;
    wait_done(3); chk_mem("mem_busy_start");
    poke(0, 32'h1111_AAAA); poke(1, 32'h2222_BBBB);
    copy(7'h00, 7'h01, 2); wait_done(2);
    chk("overlap_m1", mem[1], 32'h1111_AAAA);
    chk("overlap_m2", mem[2], 32'h1111_AAAA);
    copy(7'h33, 7'h35, 8'd128); wait_done(128); chk_mem("mem_full");
    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] s, d;
      logic [AW:0] l;
      s = AW'($urandom);
      d = AW'($urandom);
      if (d == s) d = d + 1;
      l = ($urandom % 3 == 0) ? (AW+1)'($urandom_range(0, 2)) : (AW+1)'($urandom_range(1, 20));
      copy(s, d, l); wait_done(int'(l));
    end
    chk_mem("mem_random");
    copy(7'h00, 7'h40, 20);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_done", done_o, 0);
    chk("async_we", mem_we_o, 0);
    chk("async_waddr", mem_waddr_o, 0);
    wq.delete(); rq.delete(); dq_cyc.delete(); dq_busy.delete();
    busy_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) ref_m[i] = mem[i];
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy_o, 0);
    copy(7'h50, 7'h10, 5); wait_done(5); chk_mem("mem_after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
